// File: rtl/periph_bus_fabric.sv
// Peripheral fabric: decodes mem_addr[31:16] to a registered one-hot slave select; optional abort timer under BUS_TIMEOUT_EN.
// Latency: busy for the strobe cycle plus every WAIT cycle (min 2); the CPU stalls via mem_rbusy/mem_wbusy until s_ready.
module periph_bus_fabric #(
    parameter int          NSLV    = 8,
    parameter logic [15:0] BASE_HI = 16'h0040,
    parameter int          TIMEOUT = 255,
    parameter int          TO_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wmask,
    input  logic                 mem_rstrb,
    output logic [31:0]          mem_rdata,
    output logic                 mem_rbusy,
    output logic                 mem_wbusy,
    output logic [NSLV-1:0]      s_cs,
    output logic                 s_rd,
    output logic                 s_wr,
    output logic [4:0]           s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wmask,
    input  logic [NSLV*32-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ready,
    output logic                 bus_err
);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [SW-1:0] slot;
    logic [SW-1:0] dec_slot;
    logic          op_wr;
    logic          req_wr;
    logic          req;
    logic [15:0]   hi_off;
    logic          ready_sel;
    logic [31:0]   rd_arr [NSLV];

    assign req_wr = |mem_wmask;
    assign req    = req_wr | mem_rstrb;
    assign hi_off = mem_addr[31:16] - BASE_HI;

    // Anything outside the peripheral window falls through to the RAM slot.
    always_comb begin
        dec_slot = '0;
        if (mem_addr[31:16] >= BASE_HI && hi_off <= 16'(NSLV - 2))
            dec_slot = SW'(hi_off + 16'd1);
    end

    for (genvar k = 0; k < NSLV; k++) begin : g_rd
        assign rd_arr[k] = s_rdata[32*k +: 32];
    end

    assign ready_sel = s_ready[slot];

    assign mem_rbusy = (state == IDLE) ? (mem_rstrb & ~req_wr) : ~op_wr;
    assign mem_wbusy = (state == IDLE) ? req_wr : op_wr;

`ifdef BUS_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT[0], TO_W[0]};
    assign bus_err    = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^mem_addr[15:5];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= '0;
            op_wr     <= 1'b0;
            s_cs      <= '0;
            s_rd      <= 1'b0;
            s_wr      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wmask   <= '0;
            mem_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            to_cnt    <= '0;
            bus_err   <= 1'b0;
`endif
        end else begin
            s_rd <= 1'b0;
            s_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= WAIT;
                        slot    <= dec_slot;
                        op_wr   <= req_wr;
                        s_cs    <= NSLV'(1) << dec_slot;
                        s_rd    <= ~req_wr;
                        s_wr    <= req_wr;
                        s_addr  <= mem_addr[4:0];
                        s_wdata <= mem_wdata;
                        s_wmask <= mem_wmask;
`ifdef BUS_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (ready_sel) begin
                        state <= IDLE;
                        s_cs  <= '0;
                        if (!op_wr)
                            mem_rdata <= rd_arr[slot];
                    end
`ifdef BUS_TIMEOUT_EN
                    // to_cnt counts WAIT cycles already spent; this is the TIMEOUT-th one.
                    else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        s_cs    <= '0;
                        bus_err <= 1'b1;
                        if (!op_wr)
                            mem_rdata <= 32'hDEAD_BEEF;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_periph_bus_fabric.sv
// Randomized bench for periph_bus_fabric: a per-transaction timeline model drives expectations checked every cycle.
module tb_periph_bus_fabric;
    localparam int NSLV = 8;
    localparam int TMO  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         mem_addr, mem_wdata, mem_rdata;
    logic [3:0]          mem_wmask;
    logic                mem_rstrb, mem_rbusy, mem_wbusy;
    logic [NSLV-1:0]     s_cs, s_ready;
    logic                s_rd, s_wr, bus_err;
    logic [4:0]          s_addr;
    logic [31:0]         s_wdata;
    logic [3:0]          s_wmask;
    logic [NSLV*32-1:0]  s_rdata;

    always #5 clk = ~clk;

    periph_bus_fabric #(.NSLV(NSLV), .BASE_HI(16'h0040), .TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .s_cs(s_cs), .s_rd(s_rd),
        .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_rdata(s_rdata), .s_ready(s_ready), .bus_err(bus_err)
    );

    // Expected outputs for the current cycle
    logic [NSLV-1:0] exp_cs;
    logic            exp_rd, exp_wr, exp_rbusy, exp_wbusy, exp_err;
    logic [4:0]      exp_saddr;
    logic [31:0]     exp_swdata, exp_rdata;
    logic [3:0]      exp_swmask;

    int vec = 0;
    int err = 0;
    bit chk = 0;
    int rb_cnt = 0, wb_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [NSLV-1:0] cs_seen = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("s_cs",      32'(s_cs),      32'(exp_cs));
            cmp("s_rd",      32'(s_rd),      32'(exp_rd));
            cmp("s_wr",      32'(s_wr),      32'(exp_wr));
            cmp("mem_rbusy", 32'(mem_rbusy), 32'(exp_rbusy));
            cmp("mem_wbusy", 32'(mem_wbusy), 32'(exp_wbusy));
            cmp("s_addr",    32'(s_addr),    32'(exp_saddr));
            cmp("s_wdata",   s_wdata,        exp_swdata);
            cmp("s_wmask",   32'(s_wmask),   32'(exp_swmask));
            cmp("mem_rdata", mem_rdata,      exp_rdata);
            cmp("bus_err",   32'(bus_err),   32'(exp_err));
            if (mem_rbusy) rb_cnt++;
            if (mem_wbusy) wb_cnt++;
            if (s_rd) rd_cnt++;
            if (s_wr) wr_cnt++;
            cs_seen = cs_seen | s_cs;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec, err + 1);
        $fatal(1, "watchdog");
    end

    function automatic int slot_of(input logic [31:0] a);
        int hi;
        hi = int'(a[31:16]);
        if (hi >= 'h40 && hi <= 'h40 + NSLV - 2) return hi - 'h40 + 1;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_slaves();
        s_ready = NSLV'($urandom);
        for (int k = 0; k < NSLV; k++) s_rdata[32*k +: 32] = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_rstrb = 1'b0;
            mem_wmask = 4'h0;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            rand_slaves();
            exp_cs = '0; exp_rd = 1'b0; exp_wr = 1'b0; exp_rbusy = 1'b0; exp_wbusy = 1'b0;
            step();
        end
    endtask

    // One CPU access: ready comes in WAIT cycle d+1; reset (if rst_at>0) is held during WAIT cycle rst_at.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic rstrb, input int d, input int rst_at,
                       input bit use_fix, input logic [31:0] fix);
        int slot, wlen;
        bit wr, tmo;
        logic [31:0] ret;
        slot = slot_of(addr);
        wr   = |wmask;
        wlen = d + 1;
        tmo  = 0;
        ret  = '0;
`ifdef BUS_TIMEOUT_EN
        if (d + 1 > TMO) begin
            wlen = TMO;
            tmo  = 1;
        end
`endif
        mem_addr = addr; mem_wdata = wdata; mem_wmask = wmask; mem_rstrb = rstrb;
        rand_slaves();
        exp_cs = '0; exp_rd = 1'b0; exp_wr = 1'b0;
        exp_rbusy = !wr; exp_wbusy = wr;
        step();
        for (int j = 1; j <= wlen; j++) begin
            mem_addr = $urandom; mem_wdata = $urandom;
            mem_wmask = 4'($urandom); mem_rstrb = 1'($urandom);
            rand_slaves();
            s_ready[slot] = (j == d + 1);
            if (use_fix) s_rdata[32*slot +: 32] = fix;
            if (j == d + 1) ret = s_rdata[32*slot +: 32];
            exp_cs = NSLV'(1) << slot;
            exp_rd = !wr && j == 1;
            exp_wr = wr && j == 1;
            exp_rbusy = !wr; exp_wbusy = wr;
            exp_saddr = addr[4:0]; exp_swdata = wdata; exp_swmask = wmask;
            if (j == rst_at) reset = 1'b1;
            step();
            if (j == rst_at) begin
                reset = 1'b0;
                mem_rstrb = 1'b0; mem_wmask = 4'h0;
                exp_cs = '0; exp_rd = 1'b0; exp_wr = 1'b0; exp_rbusy = 1'b0; exp_wbusy = 1'b0;
                exp_saddr = '0; exp_swdata = '0; exp_swmask = '0; exp_rdata = '0; exp_err = 1'b0;
                return;
            end
        end
        mem_rstrb = 1'b0; mem_wmask = 4'h0;
        exp_cs = '0; exp_rd = 1'b0; exp_wr = 1'b0; exp_rbusy = 1'b0; exp_wbusy = 1'b0;
        if (!wr) exp_rdata = tmo ? 32'hDEAD_BEEF : ret;
        if (tmo) exp_err = 1'b1;
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  wm;
        logic        rs;
        int          r, rst_at;
        reset = 1'b1;
        mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
        s_ready = '0; s_rdata = '0;
        exp_cs = '0; exp_rd = 1'b0; exp_wr = 1'b0; exp_rbusy = 1'b0; exp_wbusy = 1'b0;
        exp_saddr = '0; exp_swdata = '0; exp_swmask = '0; exp_rdata = '0; exp_err = 1'b0;
        step();
        chk = 1;
        step(); step();
        reset = 1'b0;
        idle(2);

        // T1: read slot 2, ready in first WAIT cycle
        rb_cnt = 0; rd_cnt = 0; cs_seen = '0;
        txn(32'h0041_0004, 32'h0, 4'h0, 1'b1, 0, 0, 1, 32'h1234_5678);
        cmp("t1_rdata", mem_rdata, 32'h1234_5678);
        cmp("t1_rbusy_cycles", 32'(rb_cnt), 32'd2);
        cmp("t1_rd_pulses", 32'(rd_cnt), 32'd1);
        cmp("t1_cs", 32'(cs_seen), 32'h04);
        cmp("t1_saddr", 32'(s_addr), 32'h04);
        idle(1);

        // T2: write slot 1, ready in third WAIT cycle
        wb_cnt = 0; wr_cnt = 0;
        txn(32'h0040_0000, 32'h41, 4'hF, 1'b0, 2, 0, 0, 32'h0);
        cmp("t2_wbusy_cycles", 32'(wb_cnt), 32'd4);
        cmp("t2_wr_pulses", 32'(wr_cnt), 32'd1);
        cmp("t2_rdata_kept", mem_rdata, 32'h1234_5678);
        cmp("t2_swdata", s_wdata, 32'h41);
        idle(1);

        // T3: low address and out-of-window address both hit slot 0
        cs_seen = '0;
        txn(32'h0000_0010, 32'h0, 4'h0, 1'b1, 1, 0, 1, 32'h0BAD_F00D);
        cmp("t3a_cs", 32'(cs_seen), 32'h01);
        cmp("t3a_rdata", mem_rdata, 32'h0BAD_F00D);
        cs_seen = '0;
        txn(32'h0050_0000, 32'h0, 4'h0, 1'b1, 0, 0, 1, 32'h600D_0001);
        cmp("t3b_cs", 32'(cs_seen), 32'h01);
        cmp("t3b_rdata", mem_rdata, 32'h600D_0001);
        cs_seen = '0;
        txn(32'h0047_0000, 32'h0, 4'h0, 1'b1, 0, 0, 1, 32'h600D_0002);
        cmp("t3c_cs", 32'(cs_seen), 32'h01);
        idle(1);

        // T4: simultaneous read and write strobe -> write only
        rd_cnt = 0; wr_cnt = 0; rb_cnt = 0;
        txn(32'h0044_0000, 32'hCAFE_0004, 4'h3, 1'b1, 1, 0, 0, 32'h0);
        cmp("t4_rd_pulses", 32'(rd_cnt), 32'd0);
        cmp("t4_wr_pulses", 32'(wr_cnt), 32'd1);
        cmp("t4_rbusy_cycles", 32'(rb_cnt), 32'd0);
        idle(1);

        // T5: reset in second WAIT cycle, then a normal read to slot 3
        txn(32'h0045_0000, 32'h0, 4'h0, 1'b1, 5, 2, 0, 32'h0);
        cmp("t5_rdata_cleared", mem_rdata, 32'h0);
        cmp("t5_cs_cleared", 32'(s_cs), 32'h0);
        cmp("t5_rbusy_cleared", 32'(mem_rbusy), 32'h0);
        idle(1);
        txn(32'h0042_0008, 32'h0, 4'h0, 1'b1, 1, 0, 1, 32'hA5A5_0003);
        cmp("t5_rdata_after", mem_rdata, 32'hA5A5_0003);
        cmp("t5_saddr_after", 32'(s_addr), 32'h08);
        idle(1);

`ifdef BUS_TIMEOUT_EN
        // T6: slot 4 never answers
        rb_cnt = 0;
        txn(32'h0043_0000, 32'h0, 4'h0, 1'b1, 20, 0, 0, 32'h0);
        cmp("t6_rbusy_cycles", 32'(rb_cnt), 32'(TMO + 1));
        cmp("t6_rdata", mem_rdata, 32'hDEAD_BEEF);
        cmp("t6_bus_err", 32'(bus_err), 32'h1);
        idle(1);
        txn(32'h0041_0000, 32'h0, 4'h0, 1'b1, 0, 0, 1, 32'h0000_0006);
        cmp("t6_bus_err_sticky", 32'(bus_err), 32'h1);
        idle(1);
`endif

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 3);
            a = $urandom;
            case (r)
                0: a[31:16] = 16'(16'h0040 + $urandom_range(0, NSLV - 2));
                1: a[31:16] = ($urandom_range(0, 1) == 1) ? 16'h0047 : 16'h003F;
                2: a[31:16] = 16'($urandom);
                default: a[31:16] = 16'h0000;
            endcase
            wd = $urandom;
            wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            rs = 1'($urandom);
            if (wm == 4'h0) rs = 1'b1;
            rst_at = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
            txn(a, wd, wm, rs, $urandom_range(0, 6), rst_at, 0, 32'h0);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
